jtag_dr_demux: RTL
==================

// Module: jtag_dr_demux
// PURPOSE
//  Receive-side counterpart of the TDO output mux: routes serial TDI into one of two
//  JTAG data registers (1-bit BYPASS or W-bit USER DR) selected by Sel. Implements
//  Capture/Shift/Update on TCK and presents a parallel update word with a valid strobe.
//  Checks the shift length. Sits between the TAP controller and user logic.
// PARAMETERS
//  W          8      USER DR width in bits (>=2)
//  RESET_VAL  0      UpdOut value after reset (W bits)
//  STRICT     1      1: Update applies only if exactly W bits were shifted; 0: always applies
// PORTS
//  TCK        in   1   test clock; all state changes on the rising edge
//  TRST_n     in   1   asynchronous active-low reset
//  TDI        in   1   serial data in
//  Sel        in   1   0 = BYPASS, 1 = USER DR (from instruction decode)
//  CaptureDR  in   1   TAP Capture-DR state
//  ShiftDR    in   1   TAP Shift-DR state
//  UpdateDR   in   1   TAP Update-DR state
//  CapIn      in   W   parallel value loaded on Capture (USER DR)
//  ShiftOut1  out  1   BYPASS serial out (= bypass bit)
//  ShiftOut2  out  1   USER DR serial out (= shift_reg[0])
//  UpdOut     out  W   parallel update register
//  UpdValid   out  1   one-cycle pulse when UpdOut is written
//  LenErr     out  1   sticky shift-length error; cleared by the next Capture
// BEHAVIOUR
//  Reset (TRST_n=0, async): bypass=0, shift_reg=0, UpdOut=RESET_VAL, UpdValid=0,
//   LenErr=0, bit_cnt=0. This holds regardless of the control inputs, including mid-shift.
//  Priority: CaptureDR > ShiftDR > UpdateDR. A lower-priority strobe asserted in the same
//   cycle as a higher one is ignored.
//  bit_cnt: $clog2(W+2) bits, internal.
//   - Cleared on Capture.
//   - +1 on each Shift with Sel=1.
//   - Saturates at W+1 (overrun marker).
//  Capture:
//   - Sel=1: shift_reg<=CapIn.
//   - Sel=0: bypass<=0.
//   - In both cases, LenErr<=0.
//  Shift:
//   - Sel=1: shift_reg<={TDI, shift_reg[W-1:1]}, LSB out first.
//   - Sel=0: bypass<=TDI.
//   - The unselected register holds.
//  ShiftOut1/ShiftOut2: combinational from register state. Each is valid before the
//   rising edge of the shift cycle.
//  Update with Sel=1:
//   - If bit_cnt==W or STRICT=0: UpdOut<=shift_reg and UpdValid=1 for the next cycle only.
//   - If bit_cnt!=W: LenErr<=1 (with STRICT=1, UpdOut holds and UpdValid stays 0).
//  Update with Sel=0: no effect on UpdOut, UpdValid or LenErr.
//  Sel is expected static from Capture to Update. A Sel change mid-sequence redirects the
//   remaining bits and is reported only through bit_cnt/LenErr.
//  UpdValid is 0 in every cycle that does not directly follow a successful Update.
//  No state changes when none of the three strobes is asserted.
// TESTING (W=8, RESET_VAL=0)
//  1 Reset mid-shift: assert TRST_n=0 between TCK edges -> immediately UpdOut=8'h00,
//    UpdValid=0, LenErr=0, ShiftOut1=0, ShiftOut2=0.
//  2 Sel=1, Capture CapIn=8'hA5, then 8 Shifts of TDI=8'h3C LSB-first
//    -> ShiftOut2 = 1,0,1,0,0,1,0,1; then Update -> UpdOut=8'h3C, UpdValid high 1 cycle, LenErr=0.
//  3 Sel=0, Capture, then Shift TDI=1,0,1 -> ShiftOut1 = 0,1,0,1 (1-bit delay);
//    shift_reg and UpdOut unchanged; Update -> UpdValid=0.
//  4 STRICT=1, Sel=1: 7 Shifts then Update -> UpdOut unchanged, UpdValid=0, LenErr=1;
//    repeat with 9 Shifts -> LenErr=1; next Capture -> LenErr=0.
//  5 CaptureDR and ShiftDR asserted in the same cycle with CapIn=8'hFF -> shift_reg=8'hFF,
//    bit_cnt=0; a following 8-bit shift and Update succeed with LenErr=0.
//  6 STRICT=0, Sel=1: 7 Shifts then Update -> UpdOut<=shift_reg, UpdValid pulses, LenErr=1.

Source files
------------

// File: rtl/jtag_dr_demux_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtag_dr_demux_if : TAP-side strobes/data and user-side DR results    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface jtag_dr_demux_if #(
  parameter int W = 8
);
  logic         TDI;
  logic         Sel;
  logic         CaptureDR;
  logic         ShiftDR;
  logic         UpdateDR;
  logic [W-1:0] CapIn;
  logic         ShiftOut1;
  logic         ShiftOut2;
  logic [W-1:0] UpdOut;
  logic         UpdValid;
  logic         LenErr;

  modport master (
    output TDI, Sel, CaptureDR, ShiftDR, UpdateDR, CapIn,
    input  ShiftOut1, ShiftOut2, UpdOut, UpdValid, LenErr
  );

  modport slave (
    input  TDI, Sel, CaptureDR, ShiftDR, UpdateDR, CapIn,
    output ShiftOut1, ShiftOut2, UpdOut, UpdValid, LenErr
  );
endinterface
`default_nettype wire

// File: rtl/jtag_dr_demux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtag_dr_demux : routes TDI into BYPASS or a W-bit USER DR, with     |
// | Capture/Shift/Update, update strobe and shift-length checking.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module jtag_dr_demux #(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0,
  parameter bit           STRICT    = 1'b1
) (
  input  wire            TCK,
  input  wire            TRST_n,
  jtag_dr_demux_if.slave dr_if
);
  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] C_CNT_FULL = CW'(W);
  localparam logic [CW-1:0] C_CNT_OVER = CW'(W + 1);

  logic          bypass_q, bypass_d;
  logic [W-1:0]  shift_q,  shift_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [W-1:0]  upd_q,    upd_d;
  logic          valid_q,  valid_d;
  logic          lenerr_q, lenerr_d;

  always_comb begin
    bypass_d = bypass_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    upd_d    = upd_q;
    valid_d  = 1'b0;
    lenerr_d = lenerr_q;
    if (dr_if.CaptureDR) begin
      cnt_d    = '0;
      lenerr_d = 1'b0;
      if (dr_if.Sel) shift_d  = dr_if.CapIn;
      else           bypass_d = 1'b0;
    end else if (dr_if.ShiftDR) begin
      if (dr_if.Sel) begin
        shift_d = {dr_if.TDI, shift_q[W-1:1]};
        // Saturating at W+1 keeps an overrun distinguishable from an exact W.
        if (cnt_q != C_CNT_OVER) cnt_d = cnt_q + 1'b1;
      end else begin
        bypass_d = dr_if.TDI;
      end
    end else if (dr_if.UpdateDR && dr_if.Sel) begin
      if ((cnt_q == C_CNT_FULL) || !STRICT) begin
        upd_d   = shift_q;
        valid_d = 1'b1;
      end
      if (cnt_q != C_CNT_FULL) lenerr_d = 1'b1;
    end
  end

  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      bypass_q <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      upd_q    <= RESET_VAL;
      valid_q  <= 1'b0;
      lenerr_q <= 1'b0;
    end else begin
      bypass_q <= bypass_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      upd_q    <= upd_d;
      valid_q  <= valid_d;
      lenerr_q <= lenerr_d;
    end
  end

  assign dr_if.ShiftOut1 = bypass_q;
  assign dr_if.ShiftOut2 = shift_q[0];
  assign dr_if.UpdOut    = upd_q;
  assign dr_if.UpdValid  = valid_q;
  assign dr_if.LenErr    = lenerr_q;
endmodule
`default_nettype wire
